score_display_driver: RTL and testbench
=======================================

# score_display_driver

Parametrised sequential binary-to-BCD converter and multi-digit seven-segment driver for the score path. It accepts a binary score from the score tracker through a load/busy/done handshake and converts it iteratively with shift-and-add-3, one bit per cycle. It holds the last completed result and drives DIGITS seven-segment outputs with optional blinking, leading-zero blanking and an overflow indication. It sits between `score_tracker` and the ss0..ss(N) display ports in `top`.

## Interface
Parameters:
- BIN_W, 7: width of binary input; ≥1.
- DIGITS, 2: number of decimal digits converted and displayed; 1..8.
- BLINK_DIV, 100: clk cycles per blink half-period; ≥1.

Ports:
- clk  in  1  system clock (hz100 in `top`).
- nRst  in  1  reset. One clock; reset is synchronous and active-low.
- load  in  1  request conversion of `bin`; sampled only in IDLE.
- bin  in  BIN_W  unsigned binary value, captured on the accepting edge.
- blink_en  in  1  1 = blink the display at BLINK_DIV rate.
- lz_blank  in  1  1 = blank leading zero digits; digit 0 is never blanked.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: new result latched.
- overflow  out  1  latched result ≥ 10^DIGITS.
- bcd  out  4*DIGITS  latched BCD result, digit 0 in [3:0].
- seg  out  7*DIGITS  segments per digit, digit k in [7k+6:7k], bit order gfedcba, active-high.

## Operation
- FSM: IDLE, SHIFT.
  - IDLE: load=1 → capture bin into shift register, clear scratch BCD register (DIGITS+1 digits internally), bit counter = BIN_W, go to SHIFT.
  - SHIFT: each cycle add 3 to every scratch digit ≥5, then shift left one bit from shift register. Counter decrements. On last bit: latch low DIGITS digits into `bcd`, set `overflow` = (scratch digit DIGITS ≠ 0), pulse `done`, return to IDLE.
- load while busy is ignored (not queued). `bin` changes after capture have no effect.
- `bcd`/`overflow`/`seg` keep the previous result throughout SHIFT; update only with `done`.
- Segment encoding 0-9: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111.
- overflow=1: every digit shows dash 1000000, lz_blank ignored.
- lz_blank=1: digit k (k≥1) blank (0000000) when it and all higher digits are 0.
- Blink: free-running counter 0..BLINK_DIV-1; wrap toggles `phase`. blink_en=1 and phase=0 → all seg = 0. blink_en=0 → steady; counter keeps running.
- Reset values: state IDLE, busy=0, done=0, overflow=0, bcd=0, phase=1, counter=0; seg therefore shows "0" in digit 0 and 0 or blank in upper digits per lz_blank.

## Timing
- Edge E0 samples load=1 in IDLE → busy=1 after E0.
- Shifts on E1..E(BIN_W); at E(BIN_W) bcd/overflow update, busy=0, done=1 for exactly one cycle.
- Latency load-edge to done visible: BIN_W cycles (7 for default).
- load=1 during the done cycle is accepted (state is IDLE); back-to-back conversions every BIN_W+1 cycles.
- seg is combinational from bcd, overflow, phase, blink_en, lz_blank; no extra latency.
- Blink: phase toggles every BLINK_DIV cycles; first toggle after BLINK_DIV edges from reset.
- nRst=0 mid-SHIFT: conversion aborted, all state to reset values on that edge, no done pulse.

## Test plan
- Defaults, load bin=42 → busy 7 cycles, done one cycle at E7, bcd=0x42, seg digit1=1100110, digit0=1011011, overflow=0.
- DIGITS=2, bin=99 → bcd=0x99, overflow=0; then bin=100 → overflow=1, both digits 1000000, bcd=0x00.
- lz_blank=1, bin=5, DIGITS=3, BIN_W=10 → digit0=1101101, digits 1-2=0000000; bin=0 → digit0=0111111 only.
- load asserted every cycle with changing bin → only values sampled at IDLE edges converted, one done per BIN_W+1 cycles, bcd stable during busy.
- BLINK_DIV=4, blink_en=1, bcd=0x12 → seg nonzero 4 cycles, all-zero 4 cycles, repeating; blink_en=0 → steady.
- nRst=0 at E3 of conversion of 127 → busy=0, done never pulses, bcd=0, phase=1; next load of 127 completes normally (bcd=0x27, overflow=1 for DIGITS=2).

Source files
------------

// File: rtl/score_display_driver.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with a
// multi-digit seven-segment driver: blinking, leading-zero blanking, overflow dashes.
module score_display_driver #(
    parameter int BIN_W     = 7,
    parameter int DIGITS    = 2,
    parameter int BLINK_DIV = 100
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  blink_en,
    input  logic                  lz_blank,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    // Handshake: load is sampled only while idle (busy=0); the accepting edge raises
    // busy, and done pulses for one cycle on the edge that latches the new result.

    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [BIN_W-1:0] sr;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    adjusted;
    logic [SW-1:0]    scratch_next;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    blink_cnt;
    logic             phase;
    logic             upper_zero;

    always_comb begin
        adjusted = scratch;
        for (int d = 0; d <= DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        scratch_next = {adjusted[SW-2:0], sr[BIN_W-1]};
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state    <= IDLE;
            sr       <= '0;
            scratch  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        sr      <= bin;
                        scratch <= '0;
                        cnt     <= CW'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    sr      <= sr << 1;
                    cnt     <= cnt - 1'b1;
                    // The spare top digit only ever holds the part of the value >= 10^DIGITS.
                    if (cnt == CW'(1)) begin
                        bcd      <= scratch_next[4*DIGITS-1:0];
                        overflow <= |scratch_next[SW-1 -: 4];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0111111;
            4'd1:    seg_of = 7'b0000110;
            4'd2:    seg_of = 7'b1011011;
            4'd3:    seg_of = 7'b1001111;
            4'd4:    seg_of = 7'b1100110;
            4'd5:    seg_of = 7'b1101101;
            4'd6:    seg_of = 7'b1111101;
            4'd7:    seg_of = 7'b0000111;
            4'd8:    seg_of = 7'b1111111;
            4'd9:    seg_of = 7'b1100111;
            default: seg_of = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        seg        = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (bcd[4*k +: 4] == 4'd0);
            if (overflow)
                seg[7*k +: 7] = 7'b1000000;
            else if (lz_blank && (k != 0) && upper_zero)
                seg[7*k +: 7] = 7'b0000000;
            else
                seg[7*k +: 7] = seg_of(bcd[4*k +: 4]);
        end
        if (blink_en && !phase)
            seg = '0;
    end

endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver: a decimal-arithmetic reference model checked every
// cycle, plus directed literal checks for the documented scenarios.
module tb_score_display_driver;

    localparam int BIN_W     = 7;
    localparam int DIGITS    = 2;
    localparam int BLINK_DIV = 4;

    logic                clk = 1'b0;
    logic                nRst = 1'b0;
    logic                load = 1'b0;
    logic [BIN_W-1:0]    bin = '0;
    logic                blink_en = 1'b0;
    logic                lz_blank = 1'b0;
    logic                busy, done, overflow;
    logic [4*DIGITS-1:0] bcd;
    logic [7*DIGITS-1:0] seg;

    score_display_driver #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .nRst(nRst), .load(load), .bin(bin), .blink_en(blink_en),
        .lz_blank(lz_blank), .busy(busy), .done(done), .overflow(overflow),
        .bcd(bcd), .seg(seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: accepted values wait in exp_q until their result is due.
    logic [BIN_W-1:0] exp_q[$];
    int m_left  = 0;
    int m_val   = 0;
    bit m_ovf   = 0;
    bit m_done  = 0;
    int m_tick  = 0;
    bit m_phase = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b0111111;  1: return 7'b0000110;
            2: return 7'b1011011;  3: return 7'b1001111;
            4: return 7'b1100110;  5: return 7'b1101101;
            6: return 7'b1111101;  7: return 7'b0000111;
            8: return 7'b1111111;  default: return 7'b1100111;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_seg(input int val, input bit ovf);
        logic [7*DIGITS-1:0] s;
        int p;
        s = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf)                                s[7*k +: 7] = 7'b1000000;
            else if (lz_blank && k > 0 && val / p == 0) s[7*k +: 7] = 7'b0000000;
            else                                    s[7*k +: 7] = digit_seg((val / p) % 10);
            p = p * 10;
        end
        if (blink_en && !m_phase) s = '0;
        return s;
    endfunction

    function automatic logic [4*DIGITS-1:0] exp_bcd(input int val);
        logic [4*DIGITS-1:0] b;
        int p;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            b[4*k +: 4] = 4'((val / p) % 10);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic model_edge();
        int lim;
        lim = 1;
        for (int k = 0; k < DIGITS; k++) lim = lim * 10;
        if (!nRst) begin
            exp_q.delete();
            m_left = 0; m_val = 0; m_ovf = 0; m_done = 0; m_tick = 0; m_phase = 1;
            return;
        end
        m_done = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_val  = int'(exp_q[0]);
                void'(exp_q.pop_front());
                m_ovf  = (m_val >= lim);
                m_val  = m_val % lim;
                m_done = 1;
            end
        end else if (load) begin
            exp_q.push_back(bin);
            m_left = BIN_W;
        end
        m_tick++;
        if (m_tick == BLINK_DIV) begin
            m_tick  = 0;
            m_phase = !m_phase;
        end
    endtask

    // One clock: advance the model on the edge, then compare away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_done));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("bcd", 64'(bcd), 64'(exp_bcd(m_val)));
        chk("seg", 64'(seg), 64'(exp_seg(m_val, m_ovf)));
    endtask

    task automatic convert(input int v);
        int n;
        load = 1'b1;
        bin  = BIN_W'(v);
        step();
        load = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("done_latency", 64'(n), 64'(BIN_W));
    endtask

    initial begin
        int nz;
        repeat (3) step();
        chk("reset_bcd", 64'(bcd), 64'h0);
        chk("reset_seg", 64'(seg), {50'h0, 7'b0111111, 7'b0111111});
        nRst = 1'b1;
        step();

        convert(42);
        chk("lit_42_bcd", 64'(bcd), 64'h42);
        chk("lit_42_seg", 64'(seg), {50'h0, 7'b1100110, 7'b1011011});
        step();
        chk("lit_done_one_cycle", 64'(done), 64'h0);

        convert(99);
        chk("lit_99_bcd", 64'(bcd), 64'h99);
        chk("lit_99_ovf", 64'(overflow), 64'h0);
        convert(100);
        chk("lit_100_ovf", 64'(overflow), 64'h1);
        chk("lit_100_seg", 64'(seg), {50'h0, 7'b1000000, 7'b1000000});
        chk("lit_100_bcd", 64'(bcd), 64'h00);

        lz_blank = 1'b1;
        convert(5);
        chk("lit_lz_5", 64'(seg), {50'h0, 7'b0000000, 7'b1101101});
        convert(0);
        chk("lit_lz_0", 64'(seg), {50'h0, 7'b0000000, 7'b0111111});
        lz_blank = 1'b0;

        // Load held high with a changing value: only idle-edge samples convert.
        load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bin = BIN_W'($urandom);
            step();
        end
        load = 1'b0;
        repeat (BIN_W + 1) step();

        convert(12);
        blink_en = 1'b1;
        nz = 0;
        for (int i = 0; i < 2 * BLINK_DIV; i++) begin
            step();
            if (seg != '0) nz++;
        end
        chk("lit_blink_on_cycles", 64'(nz), 64'(BLINK_DIV));
        blink_en = 1'b0;
        repeat (5) step();

        load = 1'b1;
        bin  = BIN_W'(127);
        step();
        load = 1'b0;
        step();
        step();
        nRst = 1'b0;
        step();
        chk("lit_abort_busy", 64'(busy), 64'h0);
        chk("lit_abort_bcd", 64'(bcd), 64'h0);
        nRst = 1'b1;
        repeat (BIN_W + 2) step();
        convert(127);
        chk("lit_127_bcd", 64'(bcd), 64'h27);
        chk("lit_127_ovf", 64'(overflow), 64'h1);

        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 1) == 1);
            bin      = BIN_W'($urandom);
            lz_blank = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 30) == 0) blink_en = !blink_en;
            nRst     = ($urandom_range(0, 150) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
